rng_byte_packer: RTL

RNG_BYTE_PACKER -- requirements
Module: rng_byte_packer

---
 rtl/rng_byte_packer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rng_byte_packer.sv
// rng_byte_packer: buffers 12-bit RNG samples in a small FIFO and serializes
// each pair of samples {A,B} as three bytes (A[11:4], {A[3:0],B[11:8]}, B[7:0])
// over a valid/ready byte interface. Samples arriving into a full FIFO are
// dropped; drop_cnt counts them (saturating) and overflow latches.
//
// Optional feature: define RNG_PACK_WHITEN_EN to XOR every emitted byte with
// an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) that steps once per
// accepted byte. Without the macro the bytes are emitted raw.
module rng_byte_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] x_in,
    input  logic        x_valid,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [15:0] drop_cnt,
    output logic        overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, S0, S1, S2} state_t;

    // Sample FIFO storage and bookkeeping
    logic [11:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] rd_ptr_p1;
    logic [CW-1:0] count_q, count_d;

    // Serializer state and registered outputs
    state_t        state_q, state_d;
    logic [23:0]   pair_q, pair_d;
    logic [7:0]    byte_out_q;
    logic          byte_valid_q;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          overflow_q, overflow_d;

    logic          accept;
    logic          pair_avail;
    logic          full;
    logic          push;
    logic          drop;
    logic          pop;
    logic [7:0]    raw_d;
    logic [7:0]    emit_d;

`ifdef RNG_PACK_WHITEN_EN
    logic [7:0]    lfsr_q, lfsr_d;
`endif

    assign rd_ptr_p1 = rd_ptr_q + PW'(1);

    // Next-state logic: FIFO push/drop decision, pair pop and serializer step
    always_comb begin
        accept     = byte_valid_q && byte_ready;
        pair_avail = count_q >= CW'(2);
        // Full is judged on the start-of-cycle count, so a same-cycle pop
        // does not rescue a sample that arrives into a full FIFO.
        full       = count_q == CW'(FIFO_DEPTH);
        push       = x_valid && !full;
        drop       = x_valid && full;

        pop        = 1'b0;
        state_d    = state_q;
        pair_d     = pair_q;
        case (state_q)
            IDLE: begin
                if (pair_avail) begin
                    pop     = 1'b1;
                    state_d = S0;
                end
            end
            S0: if (accept) state_d = S1;
            S1: if (accept) state_d = S2;
            S2: begin
                if (accept) begin
                    // Reload directly from S2 so back-to-back triples have no gap.
                    if (pair_avail) begin
                        pop     = 1'b1;
                        state_d = S0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) pair_d = {mem_q[rd_ptr_q], mem_q[rd_ptr_p1]};

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(2) : rd_ptr_q;
        count_d  = count_q + CW'(push) - (pop ? CW'(2) : CW'(0));

        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        overflow_d = overflow_q || drop;

        case (state_d)
            S0:      raw_d = pair_d[23:16];
            S1:      raw_d = pair_d[15:8];
            S2:      raw_d = pair_d[7:0];
            default: raw_d = 8'h00;
        endcase

`ifdef RNG_PACK_WHITEN_EN
        lfsr_d = accept ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]}
                        : lfsr_q;
        emit_d = (state_d == IDLE) ? 8'h00 : (raw_d ^ lfsr_d);
`else
        emit_d = raw_d;
`endif
    end

    // FIFO storage write; samples seen during reset are never stored
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= x_in;
    end

    // State, pointers, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pair_q       <= 24'h000000;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            drop_cnt_q   <= 16'h0000;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pair_q       <= pair_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            byte_out_q   <= emit_d;
            byte_valid_q <= state_d != IDLE;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef RNG_PACK_WHITEN_EN
    // Whitening LFSR: steps only when a byte is accepted
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end
`endif

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign drop_cnt   = drop_cnt_q;
    assign overflow   = overflow_q;

endmodule
